// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage in front of the decoder and immediate extender. It issues word
// fetches to instruction memory and buffers the returned words, each with its
// PC, in a small in-order queue. The head of the queue is presented to decode
// over a valid/ready handshake. A branch/jump redirect flushes the queue and
// discards every fetch that is still in flight.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     queue entries and maximum outstanding fetches (power of 2, >= 2)
//
// Ports
//   clk          in   1   single clock, rising edge
//   reset        in   1   synchronous, active-high
//   imem_req     out  1   fetch request (held stable until imem_gnt)
//   imem_addr    out  32  fetch address, word aligned
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid, in order, >= 1 cycle after grant
//   imem_rdata   in   32  instruction word
//   redirect     in   1   PC redirect (taken branch / jal / jalr)
//   redirect_pc  in   32  redirect target (low two bits ignored)
//   instr_valid  out  1   instr / instr_pc valid
//   instr        out  32  instruction to decode / extender
//   instr_pc     out  32  PC of instr
//   instr_ready  in   1   decode consumes the head entry
//
// Build option
//   IFETCH_PERF_EN  when defined, adds two 32-bit performance counters:
//     perf_fetched  out 32  instructions popped to decode
//     perf_bubble   out 32  cycles out of reset with instr_valid low
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // queue pointer width
  localparam int unsigned CW = $clog2(DEPTH + 1);                // 0..DEPTH counters
  localparam int unsigned OW = CW + 1;                           // occupancy sum width

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t         q_mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;        // entries held in the queue
  logic [CW-1:0]  outstanding;  // granted fetches not yet responded
  logic [CW-1:0]  drop_cnt;     // in-flight responses to discard
  logic [31:0]    fetch_pc;     // address of the next / currently held request
  logic [31:0]    resp_pc;      // PC belonging to the next kept response
  logic [31:0]    redir_pc;     // target saved while a stale request is held
  logic           stale;        // held request predates the latest redirect
  logic           req_held;     // request was up last cycle and not granted

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic           pop_req;
  logic           pop;
  logic           push;
  logic           rsp_drop;
  logic           grant;
  logic           stale_grant;
  logic [OW-1:0]  occ;
  logic [31:0]    tgt_pc;
  logic           unused_pc_bits;

  // Redirect targets are forced to word alignment.
  assign tgt_pc         = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    pop_req     = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    rsp_drop    = 1'b0;
    occ         = '0;
    imem_req    = 1'b0;
    grant       = 1'b0;
    stale_grant = 1'b0;

    pop_req  = instr_valid && instr_ready;
    // A flush wins over a pop in the same cycle.
    pop      = pop_req && !redirect;
    // Responses arriving in a redirect cycle are discarded along with the flush.
    push     = imem_rvalid && (drop_cnt == '0) && !redirect;
    rsp_drop = imem_rvalid && (drop_cnt != '0);

    // Slots already claimed: queued words plus fetches in flight. A pop in
    // this cycle frees its slot early, which lets a zero-wait memory keep one
    // instruction per cycle flowing at DEPTH=2. The bound count+outstanding
    // <= DEPTH still holds next cycle, so a response always finds room.
    occ = OW'(count) + OW'(outstanding) - OW'(pop_req);

    // Once raised, the request stays up until granted (req_held), whatever
    // happens to occupancy or redirect in the meantime.
    imem_req    = !reset && (req_held || (occ < OW'(DEPTH)));
    grant       = imem_req && imem_gnt;
    stale_grant = grant && stale;
  end

  assign imem_addr = fetch_pc;

  // -------------------------------------------------------------------------
  // Fetch-side and queue-control state
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      redir_pc    <= RESET_PC;
      stale       <= 1'b0;
      req_held    <= 1'b0;
    end else begin
      req_held    <= imem_req && !imem_gnt;
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);

      if (redirect) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        resp_pc  <= tgt_pc;
        // Everything granted up to and including this cycle that has not
        // responded yet is now wrong-path. The response landing this cycle
        // is already excluded from outstanding.
        drop_cnt <= outstanding + CW'(grant) - CW'(imem_rvalid);
        if (imem_req && !imem_gnt) begin
          // The held request must keep its address until granted; remember
          // the target and mark that fetch for discard when it goes out.
          stale    <= 1'b1;
          redir_pc <= tgt_pc;
        end else begin
          stale    <= 1'b0;
          fetch_pc <= tgt_pc;
        end
      end else begin
        tail  <= tail + PW'(push);
        head  <= head + PW'(pop);
        count <= count + CW'(push) - CW'(pop);

        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end

        // A stale request that finally gets granted joins the discard count.
        drop_cnt <= drop_cnt - CW'(rsp_drop) + CW'(stale_grant);

        if (grant) begin
          if (stale) begin
            stale    <= 1'b0;
            fetch_pc <= redir_pc;
          end else begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Queue storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; an entry is only visible through
  // count, which is reset, so clearing the words would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      q_mem[tail] <= '{word: imem_rdata, pc: resp_pc};
    end
  end

  // -------------------------------------------------------------------------
  // Decode-side outputs
  // -------------------------------------------------------------------------
  // Outputs read as zero while the queue is empty, which also gives the
  // required all-zero values straight out of reset.
  always_comb begin
    instr_valid = (count != '0);
    instr       = '0;
    instr_pc    = '0;
    if (instr_valid) begin
      instr    = q_mem[head].word;
      instr_pc = q_mem[head].pc;
    end
  end

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubble  <= '0;
    end else begin
      // A pop squashed by a redirect never reaches decode and is not counted.
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (!instr_valid) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`else
  // Counters are left out of this build; the fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue (DEPTH=2, RESET_PC=0). A behavioural
// instruction memory returns addr ^ 32'hA5A5_0000 one cycle after each grant
// (responses can be held back with hold_rsp). Inputs change 1 ns after the
// rising edge; outputs are sampled there too, and the request/address seen
// in each cycle is captured 1 ns before the next edge via cyc_req/cyc_addr.
// Define IFETCH_PERF_EN to include the performance-counter checks.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubble (perf_bubble)
`endif
  );

  // Bench state
  int          n_checks = 0;
  int          n_errors = 0;
  int          grants   = 0;
  logic        gnt_en   = 1'b1;
  logic        hold_rsp = 1'b0;
  logic        cyc_req;
  logic [31:0] cyc_addr;
  logic [31:0] mem_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive the memory side, capture the request, advance.
  task automatic tick();
    if (!hold_rsp && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q.pop_front() ^ PAT;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    imem_gnt = gnt_en;
    #1;
    cyc_req  = imem_req;
    cyc_addr = imem_addr;
    if (imem_req && imem_gnt && !reset) begin
      grants++;
      mem_q.push_back(imem_addr);
    end
    if (reset) mem_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    gnt_en      = 1'b1;
    hold_rsp    = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    grants = 0;
  endtask

  // Advance until instr_valid rises, bounded; an expired bound fails the check.
  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (!instr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // ---- Reset state ------------------------------------------------------
    apply_reset();
    check("rst_req",   {31'd0, cyc_req}, 32'd0);
    check("rst_addr",  cyc_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    instr_pc, 32'h0);

    // ---- 1: zero-wait stream, one instruction per cycle from cycle 3 ------
    for (int k = 1; k <= 20; k++) begin
      if (k < 3) begin
        check($sformatf("s1_valid_c%0d", k), {31'd0, instr_valid}, 32'd0);
      end else begin
        check($sformatf("s1_valid_c%0d", k), {31'd0, instr_valid}, 32'd1);
        check($sformatf("s1_pc_c%0d", k), instr_pc, 32'((k - 3) * 4));
        check($sformatf("s1_instr_c%0d", k), instr, 32'((k - 3) * 4) ^ PAT);
      end
      tick();
      check($sformatf("s1_req_c%0d", k), {31'd0, cyc_req}, 32'd1);
      check($sformatf("s1_addr_c%0d", k), cyc_addr, 32'((k - 1) * 4));
    end
`ifdef IFETCH_PERF_EN
    check("s6_bubble", perf_bubble, 32'd2);
    check("s6_fetched", perf_fetched, 32'd18);
`endif

    // ---- 6: reset mid-run clears valid (and counters) ---------------------
    reset = 1'b1;
    tick();
    check("s6_rst_req",   {31'd0, cyc_req}, 32'd0);
    check("s6_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("s6_rst_instr", instr, 32'h0);
    check("s6_rst_pc",    instr_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    check("s6_rst_bubble",  perf_bubble, 32'd0);
    check("s6_rst_fetched", perf_fetched, 32'd0);
`endif
    reset = 1'b0;
    wait_valid("s6_restart_valid", 10);
    check("s6_restart_pc", instr_pc, 32'h0);

    // ---- 2: decode stalled, queue fills to DEPTH then resumes in order ----
    apply_reset();
    instr_ready = 1'b0;
    repeat (10) tick();
    check("s2_grants", 32'(grants), 32'd2);
    check("s2_req_low", {31'd0, cyc_req}, 32'd0);
    check("s2_hold_valid", {31'd0, instr_valid}, 32'd1);
    check("s2_hold_pc", instr_pc, 32'h0);
    check("s2_hold_instr", instr, 32'h0 ^ PAT);
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s2_drain_valid%0d", i), {31'd0, instr_valid}, 32'd1);
      check($sformatf("s2_drain_pc%0d", i), instr_pc, 32'(i * 4));
      check($sformatf("s2_drain_instr%0d", i), instr, 32'(i * 4) ^ PAT);
      tick();
    end

    // ---- 3: redirect with two fetches outstanding -------------------------
    apply_reset();
    hold_rsp = 1'b1;
    tick();
    tick();
    check("s3_outstanding", 32'(grants), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    hold_rsp = 1'b0;
    check("s3_flush_valid", {31'd0, instr_valid}, 32'd0);
    wait_valid("s3_valid", 10);
    check("s3_pc", instr_pc, 32'h0000_0100);
    check("s3_instr", instr, 32'h0000_0100 ^ PAT);

    // ---- 4: redirect in the same cycle as rvalid and a pop ----------------
    apply_reset();
    repeat (4) tick();
    check("s4_pre_pc", instr_pc, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("s4_flush_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("s4_req", {31'd0, cyc_req}, 32'd1);
    check("s4_addr", cyc_addr, 32'h0000_0200);
    wait_valid("s4_valid", 10);
    check("s4_pc0", instr_pc, 32'h0000_0200);
    tick();
    check("s4_pc1", instr_pc, 32'h0000_0204);

    // ---- 5: grant stalled while redirect pulses ---------------------------
    apply_reset();
    gnt_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      redirect    = (k == 2);
      redirect_pc = 32'h0000_0300;
      tick();
      check($sformatf("s5_req_c%0d", k), {31'd0, cyc_req}, 32'd1);
      check($sformatf("s5_addr_c%0d", k), cyc_addr, 32'h0);
    end
    redirect = 1'b0;
    check("s5_stall_valid", {31'd0, instr_valid}, 32'd0);
    gnt_en = 1'b1;
    tick();
    check("s5_stale_addr", cyc_addr, 32'h0);
    tick();
    check("s5_next_addr", cyc_addr, 32'h0000_0300);
    wait_valid("s5_valid", 10);
    check("s5_pc", instr_pc, 32'h0000_0300);
    check("s5_instr", instr, 32'h0000_0300 ^ PAT);

    // ---- 7: back-to-back redirects, last wins, PC wraps at 2^32 -----------
    apply_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    check("s7_flush_valid", {31'd0, instr_valid}, 32'd0);
    wait_valid("s7_valid", 10);
    check("s7_pc0", instr_pc, 32'hFFFF_FFFC);
    check("s7_instr0", instr, 32'hFFFF_FFFC ^ PAT);
    tick();
    check("s7_pc1", instr_pc, 32'h0000_0000);
    check("s7_instr1", instr, 32'h0000_0000 ^ PAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
